// File: rtl/store_access_arbiter.sv
// rtl/store_access_arbiter.sv - password-gated round-robin arbiter for one shared store port
//
// Optional feature macro: STORE_TIMEOUT_EN (idle-session timeout; release after TIMEOUT_CYCLES
// consecutive cycles in AUTH/SESSION without a confirm from the granted requester).
//
// Ports:
//   clock                 single clock, all logic on posedge
//   reset_n               synchronous active-low reset
//   request[NUM_REQ]      per-requester access request (level)
//   confirm[NUM_REQ]      per-requester confirm strobe
//   data_in[4*NUM_REQ]    requester i drives data_in[4*i+3:4*i]
//   grant[NUM_REQ]        registered one-hot grant
//   data_out[4]           last stored nibble
//   first_output_enable   one-cycle pulse when the stored nibble has LSB = 1
//   second_output_enable  one-cycle pulse when the stored nibble has LSB = 0
//   locked[NUM_REQ]       sticky lockout flags, cleared only by reset
//   busy                  high while in AUTH or SESSION
module store_access_arbiter #(
    parameter int         NUM_REQ        = 4,
    parameter logic [3:0] PASSWORD       = 4'b0110,
    parameter int         MAX_FAILS      = 3,
    parameter int         TIMEOUT_CYCLES = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [NUM_REQ-1:0]     request,
    input  logic [NUM_REQ-1:0]     confirm,
    input  logic [4*NUM_REQ-1:0]   data_in,
    output logic [NUM_REQ-1:0]     grant,
    output logic [3:0]             data_out,
    output logic                   first_output_enable,
    output logic                   second_output_enable,
    output logic [NUM_REQ-1:0]     locked,
    output logic                   busy
);

    localparam int IW = $clog2(NUM_REQ);
    localparam int FW = $clog2(MAX_FAILS + 1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_AUTH    = 2'd1,
        S_SESSION = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t         state, state_n;
    logic [IW-1:0]  ptr, ptr_n;
    logic [IW-1:0]  cur, cur_n;          // index of the currently granted requester
    logic [FW-1:0]  fail_cnt [NUM_REQ];

    logic [NUM_REQ-1:0] grant_n, locked_n;
    logic [3:0]         data_out_n;
    logic               en1_n, en2_n;
    logic               fail_wr;
    logic [FW-1:0]      fail_wr_val;

    logic               any_elig;
    logic [IW-1:0]      pick;
    logic               req_g, conf_g, pass_ok;
    logic [3:0]         data_g;
    logic [FW-1:0]      fail_g, fail_inc;
    logic               timeout_hit;

    // Round-robin scan from ptr. Iterating offsets from high to low lets the
    // lowest offset (closest to the pointer) overwrite earlier matches.
    always_comb begin
        logic [IW:0] s;
        any_elig = 1'b0;
        pick     = '0;
        s        = '0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            s = {1'b0, ptr} + (IW+1)'(j);
            if (s >= (IW+1)'(NUM_REQ))
                s = s - (IW+1)'(NUM_REQ);
            if (request[s[IW-1:0]] && !locked[s[IW-1:0]]) begin
                any_elig = 1'b1;
                pick     = s[IW-1:0];
            end
        end
    end

    // Only the granted requester's inputs are ever observed.
    always_comb begin
        data_g = '0;
        for (int i = 0; i < NUM_REQ; i++)
            if (cur == IW'(i))
                data_g = data_in[4*i +: 4];
    end

    assign req_g    = request[cur];
    assign conf_g   = confirm[cur];
    assign pass_ok  = (data_g == PASSWORD);
    assign fail_g   = fail_cnt[cur];
    assign fail_inc = (fail_g == FW'(MAX_FAILS)) ? fail_g : fail_g + 1'b1;

`ifdef STORE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] idle_cnt;

    assign timeout_hit = !conf_g && (idle_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clock) begin
        if (!reset_n)
            idle_cnt <= '0;
        else if ((state == S_AUTH || state == S_SESSION) && !conf_g &&
                 (state_n == S_AUTH || state_n == S_SESSION))
            idle_cnt <= idle_cnt + 1'b1;
        else
            idle_cnt <= '0;
    end
`else
    // Without the timeout a grant is never revoked for idleness.
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    // State register plus all registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state                <= S_IDLE;
            ptr                  <= '0;
            cur                  <= '0;
            grant                <= '0;
            data_out             <= '0;
            first_output_enable  <= 1'b0;
            second_output_enable <= 1'b0;
            locked               <= '0;
            for (int i = 0; i < NUM_REQ; i++)
                fail_cnt[i] <= '0;
        end else begin
            state                <= state_n;
            ptr                  <= ptr_n;
            cur                  <= cur_n;
            grant                <= grant_n;
            data_out             <= data_out_n;
            first_output_enable  <= en1_n;
            second_output_enable <= en2_n;
            locked               <= locked_n;
            if (fail_wr)
                fail_cnt[cur] <= fail_wr_val;
        end
    end

    // Next-state logic. A request drop outranks a same-cycle confirm.
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE:    if (any_elig) state_n = S_AUTH;
            S_AUTH: begin
                if (!req_g)           state_n = S_IDLE;
                else if (conf_g)      state_n = pass_ok ? S_SESSION : S_RELEASE;
                else if (timeout_hit) state_n = S_RELEASE;
            end
            S_SESSION: begin
                if (!req_g)           state_n = S_IDLE;
                else if (timeout_hit) state_n = S_RELEASE;
            end
            default:                  state_n = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs, plus busy.
    always_comb begin
        grant_n     = grant;
        ptr_n       = ptr;
        cur_n       = cur;
        data_out_n  = data_out;
        en1_n       = 1'b0;
        en2_n       = 1'b0;
        locked_n    = locked;
        fail_wr     = 1'b0;
        fail_wr_val = fail_inc;
        busy        = (state == S_AUTH) || (state == S_SESSION);
        case (state)
            S_IDLE: begin
                grant_n = '0;
                if (any_elig) begin
                    grant_n[pick] = 1'b1;
                    cur_n         = pick;
                    ptr_n         = (pick == IW'(NUM_REQ - 1)) ? '0 : pick + 1'b1;
                end
            end
            S_AUTH: begin
                if (!req_g) begin
                    grant_n = '0;
                end else if (conf_g) begin
                    fail_wr = 1'b1;
                    if (pass_ok) begin
                        fail_wr_val = '0;
                    end else begin
                        grant_n = '0;
                        if (fail_inc == FW'(MAX_FAILS))
                            locked_n[cur] = 1'b1;
                    end
                end else if (timeout_hit) begin
                    grant_n = '0;
                end
            end
            S_SESSION: begin
                if (!req_g) begin
                    grant_n = '0;
                end else if (conf_g) begin
                    data_out_n = data_g;
                    en1_n      = data_g[0];
                    en2_n      = !data_g[0];
                end else if (timeout_hit) begin
                    grant_n = '0;
                end
            end
            default: grant_n = '0;
        endcase
    end

endmodule

// File: tb/tb_store_access_arbiter.sv
// tb/tb_store_access_arbiter.sv - directed self-checking bench for store_access_arbiter
module tb_store_access_arbiter;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [3:0]  request;
    logic [3:0]  confirm;
    logic [15:0] data_in;
    logic [3:0]  grant;
    logic [3:0]  data_out;
    logic        first_output_enable;
    logic        second_output_enable;
    logic [3:0]  locked;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    store_access_arbiter dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .request              (request),
        .confirm              (confirm),
        .data_in              (data_in),
        .grant                (grant),
        .data_out             (data_out),
        .first_output_enable  (first_output_enable),
        .second_output_enable (second_output_enable),
        .locked               (locked),
        .busy                 (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_nib(input int i, input logic [3:0] v);
        data_in[4*i +: 4] = v;
    endtask

    task automatic chk_outs(input string tag, input logic [3:0] g, input logic [3:0] d,
                            input logic e1, input logic e2, input logic [3:0] l, input logic b);
        chk({tag, ".grant"},  grant, g);
        chk({tag, ".data"},   data_out, d);
        chk({tag, ".en1"},    first_output_enable, e1);
        chk({tag, ".en2"},    second_output_enable, e2);
        chk({tag, ".locked"}, locked, l);
        chk({tag, ".busy"},   busy, b);
    endtask

    task automatic wait_grant(input string tag, input logic [3:0] exp);
        for (int n = 0; n < 8 && grant !== exp; n++)
            tick();
        chk(tag, grant, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // Reset with all requesters asking
        reset_n = 1'b0; request = 4'b1111; confirm = '0; data_in = '0;
        tick(); tick();
        chk_outs("reset", 4'b0000, 4'h0, 0, 0, 4'b0000, 0);
        reset_n = 1'b1;
        tick();
        chk("first_grant", grant, 4'b0001);
        chk("auth_busy", busy, 1'b1);

        // Login and stores from requester 0
        request = 4'b0001;
        confirm = 4'b0001; set_nib(0, 4'b0110);
        tick();
        chk_outs("login", 4'b0001, 4'h0, 0, 0, 4'b0000, 1);
        set_nib(0, 4'b1011);
        tick();
        chk_outs("store_b", 4'b0001, 4'hb, 1, 0, 4'b0000, 1);
        confirm = 4'b0000;
        tick();
        chk_outs("hold_b", 4'b0001, 4'hb, 0, 0, 4'b0000, 1);
        confirm = 4'b0001; set_nib(0, 4'b0100);
        tick();
        chk_outs("store_4", 4'b0001, 4'h4, 0, 1, 4'b0000, 1);
        set_nib(0, 4'b0101);
        tick();
        chk_outs("store_5_b2b", 4'b0001, 4'h5, 1, 0, 4'b0000, 1);
        confirm = 4'b0100; set_nib(2, 4'b1111);
        tick();
        chk_outs("foreign_confirm", 4'b0001, 4'h5, 0, 0, 4'b0000, 1);
        confirm = 4'b0000;

        // Fairness: 0 drops, 2 is served next, 0 waits behind it
        request = 4'b0101;
        tick();
        request = 4'b0100;
        tick();
        chk("drop_grant", grant, 4'b0000);
        chk("drop_busy", busy, 1'b0);
        tick();
        chk("rr_grant2", grant, 4'b0100);
        request = 4'b0101;
        tick();
        chk("rr_hold2", grant, 4'b0100);
        request = 4'b0001;
        tick();
        chk("rr_drop2", grant, 4'b0000);
        tick();
        chk("rr_grant0", grant, 4'b0001);
        request = 4'b0000;
        tick();
        tick();
        chk("idle_empty", grant, 4'b0000);

        // Lockout of requester 1 after three wrong codes
        request = 4'b0010; set_nib(1, 4'b0000);
        tick();
        chk("lock_grant", grant, 4'b0010);
        for (int r = 0; r < 3; r++) begin
            confirm = 4'b0010;
            tick();
            chk("wrong_grant", grant, 4'b0000);
            chk("wrong_busy", busy, 1'b0);
            chk("wrong_locked", locked, (r == 2) ? 4'b0010 : 4'b0000);
            confirm = 4'b0000;
            if (r < 2) begin
                tick();
                chk("release_gap", grant, 4'b0000);
                tick();
                chk("regrant1", grant, 4'b0010);
            end
        end
        for (int n = 0; n < 6; n++) begin
            tick();
            chk("locked_never", grant, 4'b0000);
        end

        // Request drop beats a same-cycle store confirm
        request = 4'b0001;
        tick();
        chk("p_grant", grant, 4'b0001);
        confirm = 4'b0001; set_nib(0, 4'b0110);
        tick();
        set_nib(0, 4'b1001);
        tick();
        chk_outs("p_store", 4'b0001, 4'h9, 1, 0, 4'b0010, 1);
        confirm = 4'b0000;
        tick();
        request = 4'b0000; confirm = 4'b0001; set_nib(0, 4'b0010);
        tick();
        chk_outs("drop_vs_confirm", 4'b0000, 4'h9, 0, 0, 4'b0010, 0);
        confirm = 4'b0000;

        // A good login clears the fail counter
        request = 4'b1000; set_nib(3, 4'b0001);
        wait_grant("clr_g1", 4'b1000);
        for (int r = 0; r < 2; r++) begin
            confirm = 4'b1000;
            tick();
            confirm = 4'b0000;
            wait_grant("clr_regrant", 4'b1000);
        end
        confirm = 4'b1000; set_nib(3, 4'b0110);
        tick();
        confirm = 4'b0000;
        chk("clr_session", busy, 1'b1);
        request = 4'b0000;
        tick();
        request = 4'b1000; set_nib(3, 4'b0001);
        wait_grant("clr_g2", 4'b1000);
        confirm = 4'b1000;
        tick();
        chk("clr_not_locked", locked, 4'b0010);
        confirm = 4'b0000;

        // Session for the mid-session reset (and timeout when enabled)
        set_nib(3, 4'b0110);
        wait_grant("s_grant", 4'b1000);
        confirm = 4'b1000;
        tick();
        confirm = 4'b0000;
`ifdef STORE_TIMEOUT_EN
        for (int n = 0; n < 15; n++) begin
            tick();
            chk("to_hold", grant, 4'b1000);
        end
        tick();
        chk("to_release", grant, 4'b0000);
        chk("to_locked", locked, 4'b0010);
        tick();
        chk("to_idle", grant, 4'b0000);
        tick();
        chk("to_regrant", grant, 4'b1000);
        confirm = 4'b1000;
        tick();
        confirm = 4'b0000;
`endif
        chk("pre_reset_busy", busy, 1'b1);

        // Reset mid-session with a store confirm pending
        reset_n = 1'b0; confirm = 4'b1000; set_nib(3, 4'b0001);
        tick();
        chk_outs("mid_reset", 4'b0000, 4'h0, 0, 0, 4'b0000, 0);
        reset_n = 1'b1; confirm = 4'b0000; request = 4'b0000;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
